clock_set_ctrl: RTL and testbench
=================================

# clock_set_ctrl

Time-setting controller for the HH:MM:SS digit-counter chain. It freezes counting while the user edits hours and minutes digit by digit from two buttons. On commit it issues a one-cycle load strobe with all six digit values, which the counters apply through their `set`/`setValue` inputs. It sits between the button front end and the six digit counters, and drives the edit-select and blink signals to the display mux.

## Interface
Parameters:
- `BLINK_DIV`, default 25_000_000: clock cycles per blink half-period. Minimum 2.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `tick_in`  in  1  one-cycle 1 Hz enable from the prescaler
- `btn_mode`  in  1  level, already debounced and synchronous; rising edge advances the edit step
- `btn_inc`  in  1  level, debounced; rising edge increments the selected digit
- `btn_cancel`  in  1  level, debounced; rising edge aborts the edit
- `cur_digits`  in  24  live counter values {Ht,Hu,Mt,Mu,St,Su}, 4 bits each, BCD
- `tick_out`  out  1  gated tick to the counter chain
- `run_en`  out  1  high in RUN
- `set_pulse`  out  1  one-cycle load strobe to all six counters
- `set_val`  out  24  load values, same packing as `cur_digits`
- `edit_sel`  out  3  0 = none, 1 = Ht, 2 = Hu, 3 = Mt, 4 = Mu
- `blink`  out  1  display blanking phase for the selected digit

## Operation
- Edge detection: each button is registered once. The edge is `btn & ~btn_q`. An edge is acted on at the same clock edge at which it is sampled.
- Edge priority in the same cycle: cancel > mode > inc. Lower-priority edges are dropped.
- FSM states and transitions:
  - RUN: on a mode edge, copy Ht/Hu/Mt/Mu from `cur_digits` into shadow registers and go to E_HT.
  - E_HT: mode edge → E_HU.
  - E_HU: mode edge → E_MT.
  - E_MT: mode edge → E_MU.
  - E_MU: mode edge → COMMIT.
  - COMMIT: unconditional → RUN.
  - Any E_* state: cancel edge → RUN. No load occurs.
- Increment with wrap, applied to the selected shadow digit:
  - Ht: 0..2.
  - Hu: 0..9 if Ht < 2, else 0..3.
  - Mt: 0..5.
  - Mu: 0..9.
  - Value at the limit wraps to 0.
- Clamp on entry to E_HU: if Ht == 2 and Hu > 3, force Hu = 3.
- Out-of-range captured digit (corrupt BCD) on an inc edge: the digit becomes 0.
- COMMIT outputs:
  - `set_pulse` = 1.
  - `set_val` = {Ht,Hu,Mt,Mu,0,0}. Seconds are always zeroed.
- `set_val` holds the shadow values with seconds = 0 in every state; it is qualified only by `set_pulse`.
- `run_en` = (state == RUN).
- `tick_out` = `tick_in & run_en`. Ticks arriving during edit or COMMIT are discarded, not deferred.
- `edit_sel` follows the state: E_HT = 1 … E_MU = 4, else 0.
- Blink counter:
  - Counts 0..BLINK_DIV-1 only in E_* states.
  - At the terminal count it wraps to 0 and toggles `blink`.
  - Counter and `blink` are cleared on every digit change: mode edge, inc edge, and exit from edit. The edited digit is therefore visible immediately after any press.

## Timing
- Reset values:
  - state = RUN.
  - Shadows = 0.
  - `set_pulse` = 0, `edit_sel` = 0, `blink` = 0, `run_en` = 1, `tick_out` = 0.
  - Button history registers = 0, so a button held through reset produces no edge.
- Latency: a button edge sampled at clock edge k produces its effect on state, shadows and outputs right after edge k.
- COMMIT lasts exactly one cycle. `run_en` returns to 1 the cycle after `set_pulse`.
- Reset asserted mid-edit or in COMMIT: the next cycle is RUN with no `set_pulse`.
- Held buttons act once per rising edge. There is no auto-repeat.

## Structure
- Package `clock_ctrl_pkg` contains:
  - `typedef enum logic [2:0]` for the states RUN, E_HT, E_HU, E_MT, E_MU, COMMIT.
  - Digit-limit constants: HT_MAX = 2, HU_MAX = 9, HU_MAX_20 = 3, MT_MAX = 5, MU_MAX = 9.
  - Digit-slice index constants for the 24-bit packing.
- One sub-module, `rise_detect`: a register plus an AND gate giving a one-cycle pulse. It is instantiated three times, once per button.

## Test plan
- Reset, then idle: run_en = 1, edit_sel = 0, set_pulse = 0; tick_in pulses pass unchanged to tick_out.
- cur_digits = 12:34:56, one mode edge: edit_sel = 1, run_en = 0, shadows = 1,2,3,4; tick_in pulses are blocked.
- In E_HT from Ht = 1, two inc edges: Ht = 2, then 0.
- Hours 19, set Ht to 2, then mode: Hu clamps to 3; one inc edge gives Hu = 0.
- Set 23:59 and press mode through to commit: exactly one cycle with set_pulse = 1 and set_val = {2,3,5,9,0,0}; next cycle run_en = 1.
- Edge handling:
  - Cancel edge in E_MT: next cycle RUN, with no set_pulse.
  - Simultaneous mode + inc edges in E_HT: goes to E_HU and Ht is unchanged.
  - Reset in E_MU: next cycle RUN, with no set_pulse.

Source files
------------

// File: rtl/clock_set_ctrl_pkg.sv
// Shared types and constants for the time-setting controller.
package clock_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        E_HT   = 3'd1,
        E_HU   = 3'd2,
        E_MT   = 3'd3,
        E_MU   = 3'd4,
        COMMIT = 3'd5
    } state_t;

    localparam int DIGIT_W = 4;

    // Upper limit of each editable digit; reaching it wraps to 0 on the next increment.
    localparam logic [3:0] HT_MAX    = 4'd2;
    localparam logic [3:0] HU_MAX    = 4'd9;
    localparam logic [3:0] HU_MAX_20 = 4'd3;
    localparam logic [3:0] MT_MAX    = 4'd5;
    localparam logic [3:0] MU_MAX    = 4'd9;

    // Bit positions of each digit inside the 24-bit {Ht,Hu,Mt,Mu,St,Su} word.
    localparam int HT_LSB  = 20;
    localparam int HU_LSB  = 16;
    localparam int MT_LSB  = 12;
    localparam int MU_LSB  = 8;
    localparam int SEC_LSB = 0;
    localparam int SEC_W   = 8;

    // Wrapping increment; a digit already at or above its limit (including
    // corrupt BCD) becomes 0.
    function automatic logic [3:0] inc_wrap(input logic [3:0] d, input logic [3:0] lim);
        return (d >= lim) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button / counter-chain / display signals of the time-setting controller.
interface clock_set_ctrl_if;
    logic        tick_in;
    logic        btn_mode;
    logic        btn_inc;
    logic        btn_cancel;
    logic [23:0] cur_digits;
    logic        tick_out;
    logic        run_en;
    logic        set_pulse;
    logic [23:0] set_val;
    logic [2:0]  edit_sel;
    logic        blink;

    // Controller side.
    modport slave (
        input  tick_in, btn_mode, btn_inc, btn_cancel, cur_digits,
        output tick_out, run_en, set_pulse, set_val, edit_sel, blink
    );

    // Surrounding system side (buttons, counters, display).
    modport master (
        output tick_in, btn_mode, btn_inc, btn_cancel, cur_digits,
        input  tick_out, run_en, set_pulse, set_val, edit_sel, blink
    );
endinterface

// File: rtl/clock_set_ctrl_rise_detect.sv
// One-cycle pulse on the rising edge of an already synchronous level.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic pulse_o
);
    logic btn_q;

    // History register; cleared by reset so the first sample after reset sees no prior press.
    always_ff @(posedge clk) begin
        if (reset) btn_q <= 1'b0;
        else       btn_q <= btn_i;
    end

    assign pulse_o = btn_i & ~btn_q;
endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: freezes the HH:MM:SS chain while the user edits
// hours and minutes, then loads the edited value with a one-cycle strobe.
module clock_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic            clk,
    input  logic            reset,
    clock_set_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    state_t           state_q, state_d;
    logic [3:0]       ht_q, ht_d, hu_q, hu_d, mt_q, mt_d, mu_q, mu_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             blink_q, blink_d;

    logic mode_rise, inc_rise, cancel_rise;
    logic mode_act, inc_act, cancel_act;
    logic edit_next;
    logic unused_sec;

    rise_detect u_rd_mode   (.clk(clk), .reset(reset), .btn_i(bus.btn_mode),   .pulse_o(mode_rise));
    rise_detect u_rd_inc    (.clk(clk), .reset(reset), .btn_i(bus.btn_inc),    .pulse_o(inc_rise));
    rise_detect u_rd_cancel (.clk(clk), .reset(reset), .btn_i(bus.btn_cancel), .pulse_o(cancel_rise));

    // Live seconds are never captured; the load always zeroes them.
    assign unused_sec = ^bus.cur_digits[SEC_LSB +: SEC_W];

    // Same-cycle priority: cancel beats mode beats inc.
    assign cancel_act = cancel_rise;
    assign mode_act   = mode_rise & ~cancel_rise;
    assign inc_act    = inc_rise & ~cancel_rise & ~mode_rise;

    // State, shadow digits and blink phase registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            ht_q    <= '0;
            hu_q    <= '0;
            mt_q    <= '0;
            mu_q    <= '0;
            cnt_q   <= '0;
            blink_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ht_q    <= ht_d;
            hu_q    <= hu_d;
            mt_q    <= mt_d;
            mu_q    <= mu_d;
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
        end
    end

    // Edit sequencing and shadow-digit updates.
    always_comb begin
        state_d = state_q;
        ht_d    = ht_q;
        hu_d    = hu_q;
        mt_d    = mt_q;
        mu_d    = mu_q;
        case (state_q)
            RUN: begin
                if (mode_act) begin
                    ht_d    = bus.cur_digits[HT_LSB +: DIGIT_W];
                    hu_d    = bus.cur_digits[HU_LSB +: DIGIT_W];
                    mt_d    = bus.cur_digits[MT_LSB +: DIGIT_W];
                    mu_d    = bus.cur_digits[MU_LSB +: DIGIT_W];
                    state_d = E_HT;
                end
            end
            E_HT: begin
                if (cancel_act) begin
                    state_d = RUN;
                end else if (mode_act) begin
                    state_d = E_HU;
                    // Hours 24..29 are illegal once the tens digit is 2.
                    if (ht_q == HT_MAX && hu_q > HU_MAX_20) hu_d = HU_MAX_20;
                end else if (inc_act) begin
                    ht_d = inc_wrap(ht_q, HT_MAX);
                end
            end
            E_HU: begin
                if (cancel_act)    state_d = RUN;
                else if (mode_act) state_d = E_MT;
                else if (inc_act)  hu_d = inc_wrap(hu_q, (ht_q < HT_MAX) ? HU_MAX : HU_MAX_20);
            end
            E_MT: begin
                if (cancel_act)    state_d = RUN;
                else if (mode_act) state_d = E_MU;
                else if (inc_act)  mt_d = inc_wrap(mt_q, MT_MAX);
            end
            E_MU: begin
                if (cancel_act)    state_d = RUN;
                else if (mode_act) state_d = COMMIT;
                else if (inc_act)  mu_d = inc_wrap(mu_q, MU_MAX);
            end
            COMMIT:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Blink phase: restarts on every press so the edited digit shows at once.
    always_comb begin
        cnt_d     = cnt_q;
        blink_d   = blink_q;
        edit_next = (state_d == E_HT) || (state_d == E_HU) ||
                    (state_d == E_MT) || (state_d == E_MU);
        if (!edit_next || mode_act || inc_act) begin
            cnt_d   = '0;
            blink_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            blink_d = ~blink_q;
        end else begin
            cnt_d   = cnt_q + 1'b1;
        end
    end

    // Outputs decoded from the current state and shadow digits.
    always_comb begin
        bus.set_val                        = '0;
        bus.set_val[HT_LSB +: DIGIT_W]     = ht_q;
        bus.set_val[HU_LSB +: DIGIT_W]     = hu_q;
        bus.set_val[MT_LSB +: DIGIT_W]     = mt_q;
        bus.set_val[MU_LSB +: DIGIT_W]     = mu_q;
        bus.edit_sel                       = 3'd0;
        case (state_q)
            E_HT:    bus.edit_sel = 3'd1;
            E_HU:    bus.edit_sel = 3'd2;
            E_MT:    bus.edit_sel = 3'd3;
            E_MU:    bus.edit_sel = 3'd4;
            default: bus.edit_sel = 3'd0;
        endcase
    end

    assign bus.run_en    = (state_q == RUN);
    assign bus.set_pulse = (state_q == COMMIT);
    assign bus.tick_out  = bus.tick_in & (state_q == RUN);
    assign bus.blink     = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: table of button/tick vectors with
// hand-derived expected outputs, plus sequences for blink and reset corners.
module tb_clock_set_ctrl;

    typedef struct {
        logic [2:0]  sel;
        logic        run;
        logic        sp;
        logic        to;
        logic [23:0] sv;
    } exp_t;

    typedef struct {
        logic        m, i, c, t;
        logic [23:0] cur;
        exp_t        e;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    exp_t sb[$];
    vec_t vt[$];

    clock_set_ctrl_if bus ();

    clock_set_ctrl #(.BLINK_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void add(input logic m, i, c, t, input logic [23:0] cur,
                                input logic [2:0] sel, input logic run, sp, to,
                                input logic [23:0] sv);
        vec_t v;
        v.m = m; v.i = i; v.c = c; v.t = t; v.cur = cur;
        v.e.sel = sel; v.e.run = run; v.e.sp = sp; v.e.to = to; v.e.sv = sv;
        vt.push_back(v);
    endfunction

    // Drive one cycle of inputs, clock once, then compare against the scoreboard head.
    task automatic step(input string nm, input logic m, i, c, t,
                        input logic [23:0] cur, input exp_t e);
        exp_t x;
        sb.push_back(e);
        bus.btn_mode   = m;
        bus.btn_inc    = i;
        bus.btn_cancel = c;
        bus.tick_in    = t;
        bus.cur_digits = cur;
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s.sb: got empty scoreboard expected entry", nm);
        end else begin
            x = sb.pop_front();
            cmp({nm, ".sel"}, 24'(bus.edit_sel),  24'(x.sel));
            cmp({nm, ".run"}, 24'(bus.run_en),    24'(x.run));
            cmp({nm, ".sp"},  24'(bus.set_pulse), 24'(x.sp));
            cmp({nm, ".to"},  24'(bus.tick_out),  24'(x.to));
            cmp({nm, ".sv"},  bus.set_val,        x.sv);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] sel, input logic run, sp, to,
                                input logic [23:0] sv);
        exp_t e;
        e.sel = sel; e.run = run; e.sp = sp; e.to = to; e.sv = sv;
        return e;
    endfunction

    localparam logic [23:0] C = 24'h123456;
    localparam logic [23:0] D = 24'h195905;
    localparam logic [23:0] E = 24'h235900;
    localparam logic [23:0] F = 24'hFC0000;

    initial begin
        // ---- reset state ----
        reset = 1'b1;
        bus.btn_mode = 0; bus.btn_inc = 0; bus.btn_cancel = 0;
        bus.tick_in = 0; bus.cur_digits = C;
        @(posedge clk); @(posedge clk); #1;
        cmp("rst.sel",   24'(bus.edit_sel),  24'd0);
        cmp("rst.run",   24'(bus.run_en),    24'd1);
        cmp("rst.sp",    24'(bus.set_pulse), 24'd0);
        cmp("rst.to",    24'(bus.tick_out),  24'd0);
        cmp("rst.blink", 24'(bus.blink),     24'd0);
        cmp("rst.sv",    bus.set_val,        24'h000000);
        reset = 1'b0;

        // ---- vector table: m i c t cur | sel run sp to sv ----
        add(0,0,0,0,C, 0,1,0,0,24'h000000);
        add(0,0,0,1,C, 0,1,0,1,24'h000000);
        add(1,0,0,1,C, 1,0,0,0,24'h123400);
        add(1,0,0,1,C, 1,0,0,0,24'h123400);
        add(0,1,0,0,C, 1,0,0,0,24'h223400);
        add(0,0,0,0,C, 1,0,0,0,24'h223400);
        add(0,1,0,0,C, 1,0,0,0,24'h023400);
        add(0,0,0,0,C, 1,0,0,0,24'h023400);
        add(0,1,0,0,C, 1,0,0,0,24'h123400);
        add(0,0,0,0,C, 1,0,0,0,24'h123400);
        add(0,1,0,0,C, 1,0,0,0,24'h223400);
        add(0,0,0,0,C, 1,0,0,0,24'h223400);
        add(1,1,0,0,C, 2,0,0,0,24'h223400);
        add(0,0,0,0,C, 2,0,0,0,24'h223400);
        add(0,1,0,0,C, 2,0,0,0,24'h233400);
        add(0,0,0,0,C, 2,0,0,0,24'h233400);
        add(0,1,0,0,C, 2,0,0,0,24'h203400);
        add(0,0,0,0,C, 2,0,0,0,24'h203400);
        add(1,0,0,0,C, 3,0,0,0,24'h203400);
        add(0,0,0,0,C, 3,0,0,0,24'h203400);
        add(0,0,1,1,C, 0,1,0,1,24'h203400);
        add(0,0,0,0,C, 0,1,0,0,24'h203400);
        add(1,0,0,0,D, 1,0,0,0,24'h195900);
        add(0,0,0,0,D, 1,0,0,0,24'h195900);
        add(0,1,0,0,D, 1,0,0,0,24'h295900);
        add(0,0,0,0,D, 1,0,0,0,24'h295900);
        add(1,0,0,0,D, 2,0,0,0,24'h235900);
        add(0,0,0,0,D, 2,0,0,0,24'h235900);
        add(0,1,0,0,D, 2,0,0,0,24'h205900);
        add(0,0,0,0,D, 2,0,0,0,24'h205900);
        add(0,1,0,0,D, 2,0,0,0,24'h215900);
        add(0,0,0,0,D, 2,0,0,0,24'h215900);
        add(0,1,0,0,D, 2,0,0,0,24'h225900);
        add(0,0,0,0,D, 2,0,0,0,24'h225900);
        add(0,1,0,0,D, 2,0,0,0,24'h235900);
        add(0,0,0,0,D, 2,0,0,0,24'h235900);
        add(1,0,0,0,D, 3,0,0,0,24'h235900);
        add(0,0,0,0,D, 3,0,0,0,24'h235900);
        add(1,0,0,0,D, 4,0,0,0,24'h235900);
        add(0,0,0,0,D, 4,0,0,0,24'h235900);
        add(1,0,0,1,D, 0,0,1,0,24'h235900);
        add(0,0,0,1,D, 0,1,0,1,24'h235900);
        add(1,0,0,0,E, 1,0,0,0,24'h235900);
        add(0,0,0,0,E, 1,0,0,0,24'h235900);
        add(1,0,0,0,E, 2,0,0,0,24'h235900);
        add(0,0,0,0,E, 2,0,0,0,24'h235900);
        add(1,0,0,0,E, 3,0,0,0,24'h235900);
        add(0,0,0,0,E, 3,0,0,0,24'h235900);
        add(0,1,0,0,E, 3,0,0,0,24'h230900);
        add(0,0,0,0,E, 3,0,0,0,24'h230900);
        add(1,0,0,0,E, 4,0,0,0,24'h230900);
        add(0,0,0,0,E, 4,0,0,0,24'h230900);
        add(0,1,0,0,E, 4,0,0,0,24'h230000);
        add(0,0,0,0,E, 4,0,0,0,24'h230000);
        add(0,0,1,0,E, 0,1,0,0,24'h230000);
        add(0,0,0,0,E, 0,1,0,0,24'h230000);
        add(1,0,0,0,F, 1,0,0,0,24'hFC0000);
        add(0,0,0,0,F, 1,0,0,0,24'hFC0000);
        add(0,1,0,0,F, 1,0,0,0,24'h0C0000);
        add(0,0,0,0,F, 1,0,0,0,24'h0C0000);
        add(1,0,0,0,F, 2,0,0,0,24'h0C0000);
        add(0,0,0,0,F, 2,0,0,0,24'h0C0000);
        add(0,1,0,0,F, 2,0,0,0,24'h000000);
        add(0,0,0,0,F, 2,0,0,0,24'h000000);
        add(0,0,1,0,F, 0,1,0,0,24'h000000);
        add(0,0,0,0,F, 0,1,0,0,24'h000000);
        add(1,0,1,0,C, 0,1,0,0,24'h000000);
        add(0,0,0,0,C, 0,1,0,0,24'h000000);
        add(0,1,0,1,C, 0,1,0,1,24'h000000);
        add(0,0,0,0,C, 0,1,0,0,24'h000000);

        for (int k = 0; k < vt.size(); k++)
            step($sformatf("row%0d", k), vt[k].m, vt[k].i, vt[k].c, vt[k].t, vt[k].cur, vt[k].e);

        // ---- blink phase: BLINK_DIV = 4, toggles after four idle edit cycles ----
        step("bl.enter", 1,0,0,0,C, mk(1,0,0,0,24'h123400));
        cmp("bl.enter.blink", 24'(bus.blink), 24'd0);
        for (int k = 1; k <= 4; k++) begin
            step($sformatf("bl.idle%0d", k), 0,0,0,0,C, mk(1,0,0,0,24'h123400));
            cmp($sformatf("bl.idle%0d.blink", k), 24'(bus.blink), (k == 4) ? 24'd1 : 24'd0);
        end
        step("bl.inc", 0,1,0,0,C, mk(1,0,0,0,24'h223400));
        cmp("bl.inc.blink", 24'(bus.blink), 24'd0);
        step("bl.rel", 0,0,0,0,C, mk(1,0,0,0,24'h223400));
        cmp("bl.rel.blink", 24'(bus.blink), 24'd0);

        // ---- reset while in E_MU with a mode edge pending ----
        step("rs.hu", 1,0,0,0,C, mk(2,0,0,0,24'h223400));
        step("rs.r1", 0,0,0,0,C, mk(2,0,0,0,24'h223400));
        step("rs.mt", 1,0,0,0,C, mk(3,0,0,0,24'h223400));
        step("rs.r2", 0,0,0,0,C, mk(3,0,0,0,24'h223400));
        step("rs.mu", 1,0,0,0,C, mk(4,0,0,0,24'h223400));
        step("rs.r3", 0,0,0,0,C, mk(4,0,0,0,24'h223400));
        reset = 1'b1;
        step("rs.rst", 1,0,0,0,C, mk(0,1,0,0,24'h000000));
        cmp("rs.rst.blink", 24'(bus.blink), 24'd0);
        reset = 1'b0;
        step("rs.after", 0,0,0,1,C, mk(0,1,0,1,24'h000000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
